// File: rtl/sprite_address_gen.sv
// rtl/sprite_address_gen.sv - per-pixel sprite ROM address generator with 2-stage pipeline
//
// Purpose:
//   Decodes a 32-bit sprite descriptor, tests the current pixel against the
//   SPRITE_W x SPRITE_H sprite box and produces sprite memory addresses.
//   Stage 1 captures the pixel offsets, the hit flag, the sprite index and a
//   last-sample flag. Stage 2 forms the final address. An FSM (IDLE, ACTIVE,
//   WAIT) accepts exactly SPRITE_W samples per sprite.
//   All registers update on the falling edge of clk_pixel.
//
// Optional feature macro: SPRITE_MIRROR_EN
//   When defined, descriptor bit 29 mirrors the sprite horizontally and
//   bit 30 mirrors it vertically. When undefined, both bits are ignored.
//
// Ports:
//   clk_pixel        in   pixel clock; the falling edge is active
//   reset            in   synchronous, active-high reset
//   pixel_x          in   current screen column
//   pixel_y          in   current screen line
//   sprite_datas     in   [28:19] x, [18:9] y, [8:0] index, [29] mirror-h, [30] mirror-v
//   sprite_on        in   request to generate addresses for this sprite
//   memory_address   out  registered sprite memory address
//   addr_valid       out  memory_address belongs to an accepted sample
//   counter_finished out  one-cycle pulse alongside the last sample's output

module sprite_address_gen #(
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 10,
  parameter int SIZE_ADDRESS = 14,
  parameter int SPRITE_W     = 20,
  parameter int SPRITE_H     = 20,
  parameter logic [SIZE_ADDRESS-1:0] BG_ADDRESS = SIZE_ADDRESS'((2**SIZE_ADDRESS) - 1)
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic [SIZE_X-1:0]       pixel_x,
  input  logic [SIZE_Y-1:0]       pixel_y,
  input  logic [31:0]             sprite_datas,
  input  logic                    sprite_on,
  output logic [SIZE_ADDRESS-1:0] memory_address,
  output logic                    addr_valid,
  output logic                    counter_finished
);

  // Comparison widths carry one extra bit so that sx+SPRITE_W cannot wrap
  // when the box hangs off the right or bottom edge of the screen.
  localparam int XW   = ((SIZE_X > 10) ? SIZE_X : 10) + 1;
  localparam int YW   = ((SIZE_Y > 10) ? SIZE_Y : 10) + 1;
  localparam int CW   = $clog2(SPRITE_W);
  localparam int RW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int CNTW = $clog2(SPRITE_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t          state;
  logic [CNTW-1:0] counter;

  // Stage 1 registers
  logic          s1_valid;
  logic          s1_hit;
  logic          s1_last;
  logic [CW-1:0] s1_col;
  logic [RW-1:0] s1_row;
  logic [8:0]    s1_index;

  // Combinational decode of the current pixel against the descriptor
  logic [XW-1:0]           px_e;
  logic [XW-1:0]           sx_e;
  logic [YW-1:0]           py_e;
  logic [YW-1:0]           sy_e;
  logic [XW-1:0]           dx;
  logic [YW-1:0]           dy;
  logic                    hit_n;
  logic [CW-1:0]           col_n;
  logic [RW-1:0]           row_n;
  logic                    sample;
  logic                    last_n;
  logic [SIZE_ADDRESS-1:0] addr_n;

  // Bit 31 is reserved; bits 30:29 only matter in the mirrored build.
  logic unused_bits;
  assign unused_bits = ^sprite_datas[31:29];

  always_comb begin
    px_e  = XW'(pixel_x);
    sx_e  = XW'(sprite_datas[28:19]);
    py_e  = YW'(pixel_y);
    sy_e  = YW'(sprite_datas[18:9]);
    dx    = px_e - sx_e;
    dy    = py_e - sy_e;
    hit_n = (px_e >= sx_e) && (px_e < sx_e + XW'(SPRITE_W)) &&
            (py_e >= sy_e) && (py_e < sy_e + YW'(SPRITE_H));
`ifdef SPRITE_MIRROR_EN
    col_n = sprite_datas[29] ? (CW'(SPRITE_W - 1) - CW'(dx)) : CW'(dx);
    row_n = sprite_datas[30] ? (RW'(SPRITE_H - 1) - RW'(dy)) : RW'(dy);
`else
    col_n = CW'(dx);
    row_n = RW'(dy);
`endif
    sample = sprite_on && ((state == IDLE) || (state == ACTIVE));
    last_n = (state == ACTIVE) && (counter == CNTW'(SPRITE_W - 1));
    // Full 32-bit product/sum, then truncated to the memory address width
    addr_n = SIZE_ADDRESS'(32'(s1_index) * 32'(SPRITE_W * SPRITE_H) +
                           32'(s1_row) * 32'(SPRITE_W) + 32'(s1_col));
  end

  always_ff @(negedge clk_pixel) begin
    if (reset) begin
      state            <= IDLE;
      counter          <= '0;
      s1_valid         <= 1'b0;
      s1_hit           <= 1'b0;
      s1_last          <= 1'b0;
      s1_col           <= '0;
      s1_row           <= '0;
      s1_index         <= '0;
      memory_address   <= BG_ADDRESS;
      addr_valid       <= 1'b0;
      counter_finished <= 1'b0;
    end else begin
      // Stage 2: turn the stage-1 sample into the output address
      if (s1_valid) begin
        memory_address   <= s1_hit ? addr_n : BG_ADDRESS;
        addr_valid       <= 1'b1;
        counter_finished <= s1_last;
      end else begin
        memory_address   <= BG_ADDRESS;
        addr_valid       <= 1'b0;
        counter_finished <= 1'b0;
      end

      // Stage 1: capture the pixel on each sample edge
      s1_valid <= sample;
      s1_last  <= sample && last_n;
      if (sample) begin
        s1_hit   <= hit_n;
        s1_col   <= col_n;
        s1_row   <= row_n;
        s1_index <= sprite_datas[8:0];
      end

      // Sample sequencing
      case (state)
        IDLE: begin
          if (sprite_on) begin
            counter <= CNTW'(1);
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!sprite_on) begin
            // Aborted sprite: drop back without a finished pulse
            counter <= '0;
            state   <= IDLE;
          end else if (last_n) begin
            counter <= '0;
            state   <= WAIT;
          end else begin
            counter <= counter + CNTW'(1);
          end
        end
        WAIT: begin
          // Holding sprite_on high must not start another sprite
          if (!sprite_on) begin
            state <= IDLE;
          end
        end
        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_address_gen.sv
// tb/tb_sprite_address_gen.sv - directed table-driven bench for sprite_address_gen

module tb_sprite_address_gen;

  localparam logic [13:0] BG = 14'd16383;
`ifdef SPRITE_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic        clk_pixel;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [31:0] sprite_datas;
  logic        sprite_on;
  logic [13:0] memory_address;
  logic        addr_valid;
  logic        counter_finished;

  sprite_address_gen dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .sprite_datas     (sprite_datas),
    .sprite_on        (sprite_on),
    .memory_address   (memory_address),
    .addr_valid       (addr_valid),
    .counter_finished (counter_finished)
  );

  initial clk_pixel = 1'b1;
  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [31:0] d;
    logic        on;
    logic        rst;
    logic [13:0] ea;
    logic        ev;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  // Output expected after the edge that follows the row being pushed
  logic [13:0] nxt_a;
  logic        nxt_v;
  logic        nxt_f;

  int n_checks;
  int n_pass;

  function automatic logic [31:0] desc(input logic [9:0] x, input logic [9:0] y,
                                       input logic [8:0] idx, input logic mh, input logic mv);
    return {1'b0, mv, mh, x, y, idx};
  endfunction

  // Row whose edge either samples (smp=1, producing addr/last two edges on)
  // or not; the row's own check sees the previous sample's result.
  task automatic push(input logic [9:0] px, input logic [9:0] py, input logic [31:0] d,
                      input logic on, input logic smp, input logic [13:0] a, input logic last);
    vec_t v;
    v.px = px; v.py = py; v.d = d; v.on = on; v.rst = 1'b0;
    v.ea = nxt_a; v.ev = nxt_v; v.ef = nxt_f;
    vecs.push_back(v);
    nxt_a = smp ? a : BG;
    nxt_v = smp;
    nxt_f = smp & last;
  endtask

  task automatic push_rst(input logic on, input logic [31:0] d);
    vec_t v;
    v.px = 10'd100; v.py = 10'd53; v.d = d; v.on = on; v.rst = 1'b1;
    v.ea = BG; v.ev = 1'b0; v.ef = 1'b0;
    vecs.push_back(v);
    nxt_a = BG; nxt_v = 1'b0; nxt_f = 1'b0;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
  endtask

  initial begin
    logic [31:0] d1, d2, d3;
    int nv, nf, fin_at;
    n_checks = 0;
    n_pass   = 0;
    nxt_a = BG; nxt_v = 1'b0; nxt_f = 1'b0;
    reset = 1'b1; pixel_x = '0; pixel_y = '0; sprite_datas = '0; sprite_on = 1'b0;

    d1 = desc(10'd100, 10'd50, 9'd2, 1'b0, 1'b0);
    d2 = desc(10'd100, 10'd50, 9'd2, 1'b1, 1'b0);
    d3 = desc(10'd1015, 10'd50, 9'd0, 1'b0, 1'b0);

    // Reset and idle
    push_rst(1'b0, d1);
    push_rst(1'b0, d1);
    push(10'd0, 10'd0, d1, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd0, d1, 1'b0, 1'b0, BG, 1'b0);

    // Hit run: 860..879, then WAIT while held high, then release
    for (int i = 0; i < 20; i++)
      push(10'(100 + i), 10'd53, d1, 1'b1, 1'b1, 14'(860 + i), i == 19);
    for (int i = 0; i < 3; i++) push(10'd120, 10'd53, d1, 1'b1, 1'b0, BG, 1'b0);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);

    // Below the box: accepted samples all yield the background address
    for (int i = 0; i < 20; i++)
      push(10'(100 + i), 10'd70, d1, 1'b1, 1'b1, BG, i == 19);
    push(10'd0, 10'd70, d1, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd70, d1, 1'b0, 1'b0, BG, 1'b0);

    // Horizontal mirror bit (honoured only in the mirrored build)
    for (int i = 0; i < 20; i++)
      push(10'(100 + i), 10'd53, d2, 1'b1, 1'b1, MIRROR ? 14'(879 - i) : 14'(860 + i), i == 19);
    push(10'd0, 10'd53, d2, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd53, d2, 1'b0, 1'b0, BG, 1'b0);

    // Abort after 5 samples, then a full run proves the counter restarted
    for (int i = 0; i < 5; i++)
      push(10'(100 + i), 10'd53, d1, 1'b1, 1'b1, 14'(860 + i), 1'b0);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);
    for (int i = 0; i < 20; i++)
      push(10'(100 + i), 10'd53, d1, 1'b1, 1'b1, 14'(860 + i), i == 19);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);

    // Box past the right screen edge: x=1015..1023 hit (row 5), wrapped x misses
    for (int i = 0; i < 20; i++)
      push(10'(1015 + i), 10'd55, d3, 1'b1, 1'b1, (i <= 8) ? 14'(100 + i) : BG, i == 19);
    push(10'd0, 10'd55, d3, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd55, d3, 1'b0, 1'b0, BG, 1'b0);

    // Reset mid-sprite discards the pipeline; then a fresh sprite starts
    for (int i = 0; i < 3; i++)
      push(10'(100 + i), 10'd53, d1, 1'b1, 1'b1, 14'(860 + i), 1'b0);
    push_rst(1'b1, d1);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);
    push(10'd105, 10'd53, d1, 1'b1, 1'b1, 14'd865, 1'b0);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);
    push(10'd0, 10'd53, d1, 1'b0, 1'b0, BG, 1'b0);

    // Apply the table; inputs change away from the falling edge
    @(posedge clk_pixel);
    foreach (vecs[k]) begin
      reset        = vecs[k].rst;
      pixel_x      = vecs[k].px;
      pixel_y      = vecs[k].py;
      sprite_datas = vecs[k].d;
      sprite_on    = vecs[k].on;
      @(negedge clk_pixel);
      #1;
      chk("memory_address", k, int'(memory_address), int'(vecs[k].ea));
      chk("addr_valid", k, int'(addr_valid), int'(vecs[k].ev));
      chk("counter_finished", k, int'(counter_finished), int'(vecs[k].ef));
    end

    // Hand sequence: hold sprite_on for 40 edges; expect exactly 20 valid
    // outputs, one finished pulse coinciding with the 20th valid.
    nv = 0; nf = 0; fin_at = -1;
    pixel_y = 10'd53; sprite_datas = d1; sprite_on = 1'b1; reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pixel_x = 10'(100 + (i % 20));
      @(negedge clk_pixel);
      #1;
      if (addr_valid) nv++;
      if (counter_finished) begin
        nf++;
        fin_at = nv;
      end
    end
    sprite_on = 1'b0;
    chk("held_valid_count", 0, nv, 20);
    chk("held_finish_count", 0, nf, 1);
    chk("held_finish_position", 0, fin_at, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
